// File: rtl/cl_fsb_pkg.sv
// Shared FSB packet definitions for the word packer and its packet FIFO.
// Contents: FSB_WIDTH, WORDS_PER_PKT, the fsb_pkt_t payload and the assembly-state enum.
package cl_fsb_pkg;

    localparam int unsigned FSB_WIDTH     = 80;
    localparam int unsigned WORDS_PER_PKT = 3;

    // Payload in FSB ring order: third word's low half on top, first word at the bottom.
    typedef struct packed {
        logic [15:0] w2;
        logic [31:0] w1;
        logic [31:0] w0;
    } fsb_pkt_t;

    // Assembly state names the index of the next word to be loaded.
    typedef enum logic [1:0] {
        ST_W0 = 2'd0,
        ST_W1 = 2'd1,
        ST_W2 = 2'd2
    } asm_state_e;

endpackage : cl_fsb_pkg

// File: rtl/fsb_pkt_fifo.sv
// Packet FIFO holding assembled FSB packets; head is presented with a valid/yumi handshake.
// Ports:
//   clk, pipe_rst_n   clock, asynchronous active-low reset
//   v_i, data_i       push request and packet (ignored while full)
//   full_o            occupancy equals FIFO_DEPTH
//   v_o, data_o       head valid and head packet
//   yumi_i            consumer takes the head (ignored while empty)
//   occupancy_o       number of stored packets
module fsb_pkt_fifo
    import cl_fsb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          pipe_rst_n,
    input  logic                          v_i,
    input  fsb_pkt_t                      data_i,
    output logic                          full_o,
    output logic                          v_o,
    output fsb_pkt_t                      data_o,
    input  logic                          yumi_i,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy_o
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = AW + 1;

    fsb_pkt_t           mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]   count_q;
    logic               push, pop;

    assign full_o      = (count_q == OCC_W'(FIFO_DEPTH));
    assign v_o         = (count_q != '0);
    assign data_o      = mem_q[rd_ptr_q];
    assign occupancy_o = count_q;

    assign push = v_i && !full_o;
    assign pop  = yumi_i && v_o;

    // Storage is cleared on reset so the head reads zero with nothing queued.
    always_ff @(posedge clk or negedge pipe_rst_n) begin
        if (!pipe_rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge pipe_rst_n) begin
        if (!pipe_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= AW'(wr_ptr_q + AW'(1));
            if (pop)  rd_ptr_q <= AW'(rd_ptr_q + AW'(1));
            case ({push, pop})
                2'b10:   count_q <= OCC_W'(count_q + OCC_W'(1));
                2'b01:   count_q <= OCC_W'(count_q - OCC_W'(1));
                default: count_q <= count_q;
            endcase
        end
    end

endmodule : fsb_pkt_fifo

// File: rtl/fsb_word_packer.sv
// Packs three input words into one 80-bit FSB packet and queues it in a packet FIFO.
// Optional statistics counters are built when FSB_WORD_PACKER_STATS_EN is defined.
// Ports:
//   clk, pipe_rst_n            clock, asynchronous active-low reset
//   word_v_i, word_i           input word valid and data
//   word_ready_o               word accepted when high together with word_v_i
//   flush_i                    discard the partially assembled packet
//   pkt_v_o, pkt_data_o        FIFO head valid and packet
//   pkt_yumi_i                 consumer takes the head packet
//   occupancy_o                FIFO entry count
//   partial_o                  one or two words of a packet are held
//   pkt_count_o, flush_count_o packets pushed / flushes while partial (stats build only)
module fsb_word_packer
    import cl_fsb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          pipe_rst_n,
    input  logic                          word_v_i,
    input  logic [WORD_WIDTH-1:0]         word_i,
    output logic                          word_ready_o,
    input  logic                          flush_i,
    output logic                          pkt_v_o,
    output logic [FSB_WIDTH-1:0]          pkt_data_o,
    input  logic                          pkt_yumi_i,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy_o,
    output logic                          partial_o
`ifdef FSB_WORD_PACKER_STATS_EN
    ,
    output logic [31:0]                   pkt_count_o,
    output logic [15:0]                   flush_count_o
`endif
);

    asm_state_e  state_q, state_d;
    fsb_pkt_t    asm_q, asm_d;
    fsb_pkt_t    push_pkt;
    fsb_pkt_t    head_pkt;
    logic        push;
    logic        fifo_full;
    logic        accept;
    logic [31:0] word_lo;

    assign word_lo      = word_i[31:0];
    assign word_ready_o = !flush_i && !((state_q == ST_W2) && fifo_full);
    assign accept       = word_v_i && word_ready_o;
    assign partial_o    = (state_q != ST_W0);
    assign pkt_data_o   = head_pkt;

    // Assembly state and partial packet register.
    always_ff @(posedge clk or negedge pipe_rst_n) begin
        if (!pipe_rst_n) begin
            state_q <= ST_W0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
        end
    end

    // Next-state: flush wins over any word presented in the same cycle.
    always_comb begin
        state_d  = state_q;
        asm_d    = asm_q;
        push     = 1'b0;
        push_pkt = asm_q;
        if (flush_i) begin
            state_d = ST_W0;
            asm_d   = '0;
        end else if (accept) begin
            case (state_q)
                ST_W0: begin
                    asm_d.w0 = word_lo;
                    state_d  = ST_W1;
                end
                ST_W1: begin
                    asm_d.w1 = word_lo;
                    state_d  = ST_W2;
                end
                ST_W2: begin
                    push_pkt.w2 = word_lo[15:0];
                    push        = 1'b1;
                    asm_d       = '0;
                    state_d     = ST_W0;
                end
                default: begin
                    state_d = ST_W0;
                    asm_d   = '0;
                end
            endcase
        end
    end

    fsb_pkt_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .pipe_rst_n  (pipe_rst_n),
        .v_i         (push),
        .data_i      (push_pkt),
        .full_o      (fifo_full),
        .v_o         (pkt_v_o),
        .data_o      (head_pkt),
        .yumi_i      (pkt_yumi_i),
        .occupancy_o (occupancy_o)
    );

`ifdef FSB_WORD_PACKER_STATS_EN
    logic [31:0] pkt_count_q;
    logic [15:0] flush_count_q;

    // Counters wrap at their natural width.
    always_ff @(posedge clk or negedge pipe_rst_n) begin
        if (!pipe_rst_n) begin
            pkt_count_q   <= '0;
            flush_count_q <= '0;
        end else begin
            if (push)                 pkt_count_q   <= 32'(pkt_count_q + 32'd1);
            if (flush_i && partial_o) flush_count_q <= 16'(flush_count_q + 16'd1);
        end
    end

    assign pkt_count_o   = pkt_count_q;
    assign flush_count_o = flush_count_q;
`endif

endmodule : fsb_word_packer

// File: tb/tb_fsb_word_packer.sv
// Directed self-checking bench for fsb_word_packer (FIFO_DEPTH=4, WORD_WIDTH=32).
module tb_fsb_word_packer;

    logic        clk;
    logic        pipe_rst_n;
    logic        word_v_i;
    logic [31:0] word_i;
    logic        word_ready_o;
    logic        flush_i;
    logic        pkt_v_o;
    logic [79:0] pkt_data_o;
    logic        pkt_yumi_i;
    logic [2:0]  occupancy_o;
    logic        partial_o;
`ifdef FSB_WORD_PACKER_STATS_EN
    logic [31:0] pkt_count_o;
    logic [15:0] flush_count_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] pw0 [5];
    logic [31:0] pw1 [5];
    logic [31:0] pw2 [5];
    logic [79:0] pexp [5];

    fsb_word_packer #(
        .FIFO_DEPTH (4),
        .WORD_WIDTH (32)
    ) dut (
        .clk          (clk),
        .pipe_rst_n   (pipe_rst_n),
        .word_v_i     (word_v_i),
        .word_i       (word_i),
        .word_ready_o (word_ready_o),
        .flush_i      (flush_i),
        .pkt_v_o      (pkt_v_o),
        .pkt_data_o   (pkt_data_o),
        .pkt_yumi_i   (pkt_yumi_i),
        .occupancy_o  (occupancy_o),
        .partial_o    (partial_o)
`ifdef FSB_WORD_PACKER_STATS_EN
        ,
        .pkt_count_o  (pkt_count_o),
        .flush_count_o(flush_count_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one word for one clock; returns 1 time unit after the edge.
    task automatic send_word(input logic [31:0] w);
        word_v_i = 1'b1;
        word_i   = w;
        @(posedge clk);
        #1;
        word_v_i = 1'b0;
    endtask

    task automatic pop_one();
        pkt_yumi_i = 1'b1;
        @(posedge clk);
        #1;
        pkt_yumi_i = 1'b0;
    endtask

    initial begin
        pipe_rst_n = 1'b0;
        word_v_i   = 1'b0;
        word_i     = '0;
        flush_i    = 1'b0;
        pkt_yumi_i = 1'b0;
        #1;
        check("rst_pkt_v", 80'(pkt_v_o), 80'd0);
        check("rst_ready", 80'(word_ready_o), 80'd1);
        check("rst_occ", 80'(occupancy_o), 80'd0);
        check("rst_partial", 80'(partial_o), 80'd0);
        check("rst_data", pkt_data_o, 80'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        pipe_rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic packing example.
        send_word(32'h1111_2222);
        check("t1_partial_w1", 80'(partial_o), 80'd1);
        send_word(32'h3333_4444);
        check("t1_no_pkt_yet", 80'(pkt_v_o), 80'd0);
        send_word(32'hFFFF_5555);
        check("t1_pkt_v", 80'(pkt_v_o), 80'd1);
        check("t1_data", pkt_data_o, 80'h5555_3333_4444_1111_2222);
        check("t1_occ", 80'(occupancy_o), 80'd1);
        check("t1_partial_w0", 80'(partial_o), 80'd0);
        pop_one();
        check("t1_pop_occ", 80'(occupancy_o), 80'd0);
        check("t1_pop_v", 80'(pkt_v_o), 80'd0);

        // Fill the FIFO, then a fifth packet stalls in W2 until the first yumi.
        for (int k = 0; k < 5; k++) begin
            pw0[k]  = 32'hA000_0000 + 32'(k);
            pw1[k]  = 32'hB000_0010 + 32'(k);
            pw2[k]  = 32'hC0DE_7700 + 32'(k);
            pexp[k] = {pw2[k][15:0], pw1[k], pw0[k]};
        end
        for (int k = 0; k < 4; k++) begin
            send_word(pw0[k]);
            send_word(pw1[k]);
            send_word(pw2[k]);
        end
        check("t2_occ_full", 80'(occupancy_o), 80'd4);
        check("t2_head0", pkt_data_o, pexp[0]);
        check("t2_ready_w0", 80'(word_ready_o), 80'd1);
        send_word(pw0[4]);
        check("t2_ready_w1", 80'(word_ready_o), 80'd1);
        send_word(pw1[4]);
        check("t2_ready_w2_full", 80'(word_ready_o), 80'd0);
        // Word held while full: must not be taken, head must stay stable.
        word_v_i = 1'b1;
        word_i   = pw2[4];
        @(posedge clk);
        #1;
        check("t2_stall_occ", 80'(occupancy_o), 80'd4);
        check("t2_stall_partial", 80'(partial_o), 80'd1);
        check("t2_head_stable", pkt_data_o, pexp[0]);
        pkt_yumi_i = 1'b1;
        @(posedge clk);
        #1;
        pkt_yumi_i = 1'b0;
        check("t2_after_yumi_occ", 80'(occupancy_o), 80'd3);
        check("t2_after_yumi_ready", 80'(word_ready_o), 80'd1);
        check("t2_after_yumi_head", pkt_data_o, pexp[1]);
        @(posedge clk);
        #1;
        word_v_i = 1'b0;
        check("t2_fifth_occ", 80'(occupancy_o), 80'd4);
        check("t2_fifth_partial", 80'(partial_o), 80'd0);
        for (int k = 1; k < 5; k++) begin
            check($sformatf("t2_order%0d", k), pkt_data_o, pexp[k]);
            pop_one();
        end
        check("t2_drained", 80'(occupancy_o), 80'd0);

        // Flush a partial packet; the word presented during flush is dropped.
        send_word(32'h0101_0101);
        send_word(32'h0202_0202);
        check("t3_partial_before", 80'(partial_o), 80'd1);
        flush_i  = 1'b1;
        word_v_i = 1'b1;
        word_i   = 32'h0303_0303;
        #1;
        check("t3_ready_flush", 80'(word_ready_o), 80'd0);
        @(posedge clk);
        #1;
        flush_i  = 1'b0;
        word_v_i = 1'b0;
        check("t3_partial_after", 80'(partial_o), 80'd0);
        check("t3_occ_after", 80'(occupancy_o), 80'd0);
`ifdef FSB_WORD_PACKER_STATS_EN
        check("t3_flush_count", 80'(flush_count_o), 80'd1);
`endif
        send_word(32'hAAAA_0001);
        send_word(32'hBBBB_0002);
        send_word(32'hCCCC_0003);
        check("t3_occ", 80'(occupancy_o), 80'd1);
        check("t3_data", pkt_data_o, 80'h0003_BBBB_0002_AAAA_0001);
        pop_one();

        // Simultaneous push and pop with one packet queued.
        send_word(32'h1000_0001);
        send_word(32'h1000_0002);
        send_word(32'h1000_0003);
        send_word(32'h2000_0001);
        send_word(32'h2000_0002);
        pkt_yumi_i = 1'b1;
        send_word(32'h2000_0003);
        pkt_yumi_i = 1'b0;
        check("t4_occ", 80'(occupancy_o), 80'd1);
        check("t4_head", pkt_data_o, 80'h0003_2000_0002_2000_0001);
        pop_one();
        check("t4_empty", 80'(occupancy_o), 80'd0);

        // Asynchronous reset mid-packet with two packets queued.
        for (int k = 0; k < 2; k++) begin
            send_word(pw0[k]);
            send_word(pw1[k]);
            send_word(pw2[k]);
        end
        send_word(32'h5555_5555);
        check("t5_pre_occ", 80'(occupancy_o), 80'd2);
        #2;
        pipe_rst_n = 1'b0;
        #1;
        check("t5_rst_v", 80'(pkt_v_o), 80'd0);
        check("t5_rst_occ", 80'(occupancy_o), 80'd0);
        check("t5_rst_partial", 80'(partial_o), 80'd0);
        check("t5_rst_data", pkt_data_o, 80'd0);
        @(negedge clk);
        pipe_rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t5_post_v", 80'(pkt_v_o), 80'd0);
        send_word(32'h0000_00A1);
        send_word(32'h0000_00B2);
        send_word(32'h1234_00C3);
        check("t5_clean_occ", 80'(occupancy_o), 80'd1);
        check("t5_clean_data", pkt_data_o, 80'h00C3_0000_00B2_0000_00A1);
        pop_one();

        // Yumi against an empty FIFO is ignored.
        pkt_yumi_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("t6_occ%0d", c), 80'(occupancy_o), 80'd0);
            check($sformatf("t6_v%0d", c), 80'(pkt_v_o), 80'd0);
        end
        pkt_yumi_i = 1'b0;
        send_word(32'h0000_0001);
        send_word(32'h0000_0002);
        send_word(32'h0000_0003);
        check("t6_after_occ", 80'(occupancy_o), 80'd1);
        check("t6_after_data", pkt_data_o, 80'h0003_0000_0002_0000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fsb_word_packer

// File: doc/fsb_word_packer.md
FSB_WORD_PACKER -- requirements
Module: fsb_word_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4; packet FIFO entries; power of two, >= 2.
REQ-002 SHALL have parameter WORD_WIDTH, default 32; input word width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port pipe_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port word_v_i  input  1  input word valid.
REQ-006 SHALL have port word_i  input  WORD_WIDTH  input word, typically AXI-L write data.
REQ-007 SHALL have port word_ready_o  output  1  input word accepted when high with word_v_i.
REQ-008 SHALL have port flush_i  input  1  discard the partially assembled packet.
REQ-009 SHALL have port pkt_v_o  output  1  FIFO head packet valid.
REQ-010 SHALL have port pkt_data_o  output  80  FIFO head packet, FSB ring format.
REQ-011 SHALL have port pkt_yumi_i  input  1  consumer takes the head packet; legal only when pkt_v_o is high.
REQ-012 SHALL have port occupancy_o  output  $clog2(FIFO_DEPTH)+1  number of FIFO entries.
REQ-013 SHALL have port partial_o  output  1  high when 1 or 2 words of a packet are held.

Function
REQ-014 SHALL run an assembly FSM with states W0, W1, W2 (next word index); W0 after reset.
REQ-015 Word in W0 SHALL load bits [31:0]; W1 -> [63:32]; W2 -> [79:64] from word_i[15:0], with word_i[31:16] ignored.
REQ-016 Transitions: accept in W0 -> W1; accept in W1 -> W2; accept in W2 -> W0, and the assembled 80-bit packet is pushed into the FIFO in the same cycle.
REQ-017 word_ready_o SHALL be: !flush_i && !(state==W2 && FIFO full); it SHALL NOT depend on pkt_yumi_i.
REQ-018 A pushed packet SHALL appear on pkt_v_o/pkt_data_o the cycle after the push (1-cycle latency from the third word).
REQ-019 FIFO SHALL be first-in first-out; a pop on pkt_yumi_i and a push in the same cycle SHALL both take effect, with occupancy unchanged.
REQ-020 FIFO full = occupancy==FIFO_DEPTH; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 pkt_data_o SHALL hold stable while pkt_v_o is high and no yumi occurs.
REQ-022 flush_i SHALL force the state to W0 and zero the assembly register next cycle; FIFO contents SHALL be unaffected; a word presented in the same cycle SHALL NOT be accepted.
REQ-023 partial_o SHALL equal (state != W0).
REQ-024 pkt_yumi_i asserted while pkt_v_o is low SHALL be ignored (no underflow).

Reset
REQ-025 Asserting pipe_rst_n low SHALL immediately clear state to W0, assembly register to 0, FIFO pointers and occupancy to 0, and stats counters to 0.
REQ-026 During reset: pkt_v_o=0, word_ready_o=1 (if flush_i low), occupancy_o=0, partial_o=0, pkt_data_o=0.
REQ-027 Reset mid-packet SHALL discard the partial packet and all FIFO entries; no packet SHALL be emitted afterwards from pre-reset data.

Configuration
REQ-028 Macro FSB_WORD_PACKER_STATS_EN SHALL, when defined, add outputs pkt_count_o[31:0] (packets pushed) and flush_count_o[15:0] (flushes while partial_o is high); both wrap modulo 2^width.
REQ-029 Without FSB_WORD_PACKER_STATS_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package cl_fsb_pkg SHALL hold FSB_WIDTH=80, WORDS_PER_PKT=3, the fsb_pkt_t 80-bit typedef, and the assembly-state enum.
REQ-031 The FIFO SHALL be sub-module fsb_pkt_fifo (parameter FIFO_DEPTH, width fsb_pkt_t, v/yumi output, occupancy).

Verification
REQ-032 Words 0x11112222, 0x33334444, 0xFFFF5555 -> pkt_data_o=80'h5555_3333_4444_1111_2222 one cycle after the third accept; occupancy_o=1.
REQ-033 Five packets written with no yumi (FIFO_DEPTH=4) -> occupancy_o=4; word_ready_o low only in W2; first yumi -> fifth packet accepted; order preserved.
REQ-034 Two words, then flush_i for 1 cycle, then three words A, B, C -> exactly one packet formed from A, B, C; partial_o returns to 0 after the flush; flush_count_o=1 with STATS_EN.
REQ-035 FIFO holding 1 packet, yumi and third-word push in the same cycle -> occupancy_o stays 1; new head is the next packet.
REQ-036 pipe_rst_n pulsed low after one word with 2 packets queued -> pkt_v_o=0, occupancy_o=0, partial_o=0 immediately; the next three words form a clean packet.
REQ-037 Yumi with empty FIFO for 3 cycles -> occupancy_o remains 0; no spurious pkt_v_o.
